cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Parameters
REQ-001 ROB_SIZE_bits, default 4, ROB index width minus 1; ROBEN is ROB_SIZE_bits+1 bits, value 0 = no broadcast.
REQ-002 NREQ, fixed 4, number of result requesters (0 = ALU0, 1 = ALU1, 2 = load/store, 3 = branch unit).

Interface
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 FLUSH_Flag  in  1  flush from the ROB; drops all pending arbitration.
REQ-006 req_valid  in  4  bit i = requester i holds a finished result.
REQ-007 req_ROBEN  in  20  packed 4x5; bits [5i+4:5i] = ROBEN of requester i.
REQ-008 req_Write_Data  in  128  packed 4x32; bits [32i+31:32i] = result of requester i.
REQ-009 req_Branch_Decision  in  4  bit i = branch outcome of requester i.
REQ-010 req_EXCEPTION  in  4  bit i = exception flag of requester i.
REQ-011 req_ready  out  4  bit i = requester i granted this cycle; combinational.
REQ-012 CDB_ROBEN1, CDB_ROBEN2  out  5 each  lane ROBEN; 0 = lane idle.
REQ-013 CDB_ROBEN1_Write_Data, CDB_ROBEN2_Write_Data  out  32 each  lane result.
REQ-014 CDB_Branch_Decision1, CDB_Branch_Decision2  out  1 each  lane branch outcome.
REQ-015 CDB_EXCEPTION1, CDB_EXCEPTION2  out  1 each  lane exception.
REQ-016 rr_ptr  out  2  current round-robin start index.

Function
REQ-017 A requester is eligible iff req_valid[i]=1 and req_ROBEN[i] != 0; ineligible requesters shall never be granted.
REQ-018 Each cycle, scan order shall be rr_ptr, rr_ptr+1, ... mod 4; the first eligible requester is grant A and the second is grant B.
REQ-019 At most 2 grants per cycle; req_ready shall be 1 exactly for grant A and grant B, else 0.
REQ-020 A transfer occurs iff req_valid[i] & req_ready[i]; requesters hold payload stable until granted.
REQ-021 Latency 1: grant A payload shall appear on lane 1 and grant B payload on lane 2 at the next posedge.
REQ-022 A lane with no grant shall drive ROBEN=0, Write_Data=0, Branch_Decision=0, EXCEPTION=0 next cycle.
REQ-023 Only grant B present is impossible; lane 2 shall never be active while lane 1 is idle.
REQ-024 rr_ptr shall update to (index of last grant this cycle + 1) mod 4 (wraps 3 -> 0); unchanged if no grant.
REQ-025 When FLUSH_Flag=1: req_ready=0000 that cycle; both lanes idle next cycle; rr_ptr unchanged.
REQ-026 Two requesters with equal nonzero ROBEN shall both be granted per normal order; no duplicate checking.
REQ-027 Outputs are registered; no combinational path from req_* to CDB_* outputs.

Reset
REQ-028 While rst=1 at posedge: both lanes idle (all CDB_* = 0), rr_ptr=0.
REQ-029 While rst=1: req_ready=0000 combinationally; rst overrides FLUSH_Flag and any in-flight grant.
REQ-030 Reset asserted mid-transfer discards the granted payload; the lanes never show it.

Verification
REQ-031 rr_ptr=0, valid=1111, ROBENs 1,2,3,4 -> ready=0011; next cycle lane1 ROBEN=1, lane2 ROBEN=2; rr_ptr=2.
REQ-032 Hold valid=1111 (payloads refreshed) -> grants {2,3}, then {0,1}, rr_ptr 2 -> 0 -> 2; no requester starved.
REQ-033 valid=0100 only, ROBEN=7, data=0xDEADBEEF, exception=1 -> ready=0100; lane1 = 7/0xDEADBEEF/exc=1; lane2 ROBEN=0; rr_ptr=3.
REQ-034 valid=1000 with req_ROBEN[3]=0 -> ready=0000; lanes idle; rr_ptr unchanged.
REQ-035 valid=1111 with FLUSH_Flag=1 -> ready=0000; lanes idle next cycle; rr_ptr holds; next cycle with FLUSH_Flag=0 arbitration resumes from the same rr_ptr.
REQ-036 rst=1 for one cycle while lanes active -> all CDB_* = 0 and rr_ptr=0 after that posedge; ready=0000 during rst.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Two-lane common data bus arbiter: round-robin picks up to two finished results per cycle, broadcast one cycle later.
// Backpressure: req_ready is the combinational grant; ungranted requesters hold their payload, and flush/reset grant nothing.
module cdb_arbiter #(
    parameter int ROB_SIZE_bits = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               FLUSH_Flag,
    input  logic [3:0]                         req_valid,
    input  logic [4*(ROB_SIZE_bits+1)-1:0]     req_ROBEN,
    input  logic [127:0]                       req_Write_Data,
    input  logic [3:0]                         req_Branch_Decision,
    input  logic [3:0]                         req_EXCEPTION,
    output logic [3:0]                         req_ready,
    output logic [ROB_SIZE_bits:0]             CDB_ROBEN1,
    output logic [ROB_SIZE_bits:0]             CDB_ROBEN2,
    output logic [31:0]                        CDB_ROBEN1_Write_Data,
    output logic [31:0]                        CDB_ROBEN2_Write_Data,
    output logic                               CDB_Branch_Decision1,
    output logic                               CDB_Branch_Decision2,
    output logic                               CDB_EXCEPTION1,
    output logic                               CDB_EXCEPTION2,
    output logic [1:0]                         rr_ptr
);

    localparam int NREQ = 4;
    localparam int RW   = ROB_SIZE_bits + 1;

    typedef struct packed {
        logic [RW-1:0] roben;
        logic [31:0]   data;
        logic          br;
        logic          exc;
    } lane_t;

    lane_t      lane1_q, lane1_d;
    lane_t      lane2_q, lane2_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] eligible;
    logic            a_vld, b_vld;
    logic [1:0]      a_idx, b_idx, scan_idx;
    logic            accept;

    function automatic lane_t lane_of(
        input logic [1:0]       idx,
        input logic [4*RW-1:0]  rob,
        input logic [127:0]     dat,
        input logic [3:0]       br,
        input logic [3:0]       exc
    );
        lane_t l;
        l.roben = rob[int'(idx)*RW +: RW];
        l.data  = dat[int'(idx)*32 +: 32];
        l.br    = br[idx];
        l.exc   = exc[idx];
        return l;
    endfunction

    // ROBEN 0 means "nothing to broadcast", so such a requester is never eligible.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (req_ROBEN[i*RW +: RW] != '0);
        end
    end

    // Scan from the round-robin pointer; first eligible wins lane 1, second lane 2.
    always_comb begin
        a_vld    = 1'b0;
        b_vld    = 1'b0;
        a_idx    = 2'd0;
        b_idx    = 2'd0;
        scan_idx = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (eligible[scan_idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = scan_idx;
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
    end

    assign accept = !(rst || FLUSH_Flag);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            if (a_vld) req_ready[a_idx] = 1'b1;
            if (b_vld) req_ready[b_idx] = 1'b1;
        end
    end

    always_comb begin
        lane1_d  = '0;
        lane2_d  = '0;
        rr_ptr_d = rr_ptr_q;
        if (accept && a_vld) begin
            lane1_d  = lane_of(a_idx, req_ROBEN, req_Write_Data, req_Branch_Decision, req_EXCEPTION);
            rr_ptr_d = a_idx + 2'd1;
        end
        // Grant B only exists when grant A does, so lane 2 is never active alone.
        if (accept && b_vld) begin
            lane2_d  = lane_of(b_idx, req_ROBEN, req_Write_Data, req_Branch_Decision, req_EXCEPTION);
            rr_ptr_d = b_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane1_q  <= '0;
            lane2_q  <= '0;
            rr_ptr_q <= 2'd0;
        end else begin
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign CDB_ROBEN1            = lane1_q.roben;
    assign CDB_ROBEN1_Write_Data = lane1_q.data;
    assign CDB_Branch_Decision1  = lane1_q.br;
    assign CDB_EXCEPTION1        = lane1_q.exc;
    assign CDB_ROBEN2            = lane2_q.roben;
    assign CDB_ROBEN2_Write_Data = lane2_q.data;
    assign CDB_Branch_Decision2  = lane2_q.br;
    assign CDB_EXCEPTION2        = lane2_q.exc;
    assign rr_ptr                = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a scan-order reference model.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         FLUSH_Flag = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [19:0]  req_ROBEN = '0;
    logic [127:0] req_Write_Data = '0;
    logic [3:0]   req_Branch_Decision = '0;
    logic [3:0]   req_EXCEPTION = '0;
    logic [3:0]   req_ready;
    logic [4:0]   CDB_ROBEN1, CDB_ROBEN2;
    logic [31:0]  CDB_ROBEN1_Write_Data, CDB_ROBEN2_Write_Data;
    logic         CDB_Branch_Decision1, CDB_Branch_Decision2;
    logic         CDB_EXCEPTION1, CDB_EXCEPTION2;
    logic [1:0]   rr_ptr;

    int checks = 0;
    int failures = 0;
    string phase = "init";

    // Requester-side view: what each unit is currently presenting.
    bit [3:0]  v;
    bit [4:0]  rob [4];
    bit [31:0] dat [4];
    bit        br  [4];
    bit        ex  [4];
    int        m_rr = 0;
    bit [3:0]  last_ready = '0;

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_SIZE_bits(4)) dut (
        .clk(clk), .rst(rst), .FLUSH_Flag(FLUSH_Flag),
        .req_valid(req_valid), .req_ROBEN(req_ROBEN),
        .req_Write_Data(req_Write_Data),
        .req_Branch_Decision(req_Branch_Decision),
        .req_EXCEPTION(req_EXCEPTION), .req_ready(req_ready),
        .CDB_ROBEN1(CDB_ROBEN1), .CDB_ROBEN2(CDB_ROBEN2),
        .CDB_ROBEN1_Write_Data(CDB_ROBEN1_Write_Data),
        .CDB_ROBEN2_Write_Data(CDB_ROBEN2_Write_Data),
        .CDB_Branch_Decision1(CDB_Branch_Decision1),
        .CDB_Branch_Decision2(CDB_Branch_Decision2),
        .CDB_EXCEPTION1(CDB_EXCEPTION1), .CDB_EXCEPTION2(CDB_EXCEPTION2),
        .rr_ptr(rr_ptr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic apply();
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_ROBEN[i*5 +: 5]           = rob[i];
            req_Write_Data[i*32 +: 32]    = dat[i];
            req_Branch_Decision[i]        = br[i];
            req_EXCEPTION[i]              = ex[i];
        end
    endtask

    // One cycle: drive, check grants mid-cycle, check broadcast after the edge.
    task automatic step(input bit do_rst, input bit do_flush);
        int g [2];
        int n;
        bit [3:0]  er;
        bit [4:0]  e1r, e2r;
        bit [31:0] e1d, e2d;
        bit        e1b, e2b, e1e, e2e;
        int        nrr;
        rst = do_rst;
        FLUSH_Flag = do_flush;
        apply();
        n = 0;
        g[0] = 0;
        g[1] = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_rr + k) % 4;
            if (v[i] && rob[i] != 0 && n < 2) begin
                g[n] = i;
                n++;
            end
        end
        er = '0;
        e1r = '0; e2r = '0; e1d = '0; e2d = '0;
        e1b = 0; e2b = 0; e1e = 0; e2e = 0;
        if (do_rst || do_flush) begin
            nrr = do_rst ? 0 : m_rr;
        end else begin
            for (int j = 0; j < n; j++) er[g[j]] = 1'b1;
            if (n >= 1) begin
                e1r = rob[g[0]]; e1d = dat[g[0]]; e1b = br[g[0]]; e1e = ex[g[0]];
            end
            if (n == 2) begin
                e2r = rob[g[1]]; e2d = dat[g[1]]; e2b = br[g[1]]; e2e = ex[g[1]];
            end
            nrr = (n > 0) ? (g[n-1] + 1) % 4 : m_rr;
        end
        @(negedge clk);
        check("ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        check("rob1", 32'(CDB_ROBEN1), 32'(e1r));
        check("dat1", CDB_ROBEN1_Write_Data, e1d);
        check("br1",  32'(CDB_Branch_Decision1), 32'(e1b));
        check("exc1", 32'(CDB_EXCEPTION1), 32'(e1e));
        check("rob2", 32'(CDB_ROBEN2), 32'(e2r));
        check("dat2", CDB_ROBEN2_Write_Data, e2d);
        check("br2",  32'(CDB_Branch_Decision2), 32'(e2b));
        check("exc2", 32'(CDB_EXCEPTION2), 32'(e2e));
        check("rr",   32'(rr_ptr), 32'(nrr));
        m_rr = nrr;
        last_ready = er;
    endtask

    task automatic new_payload(input int i);
        v[i]   = ($urandom_range(0, 3) != 0);
        rob[i] = 5'($urandom_range(0, 31));
        dat[i] = $urandom;
        br[i]  = 1'($urandom_range(0, 1));
        ex[i]  = 1'($urandom_range(0, 1));
    endtask

    task automatic set_all(input bit [3:0] vv, input int base);
        v = vv;
        for (int i = 0; i < 4; i++) begin
            rob[i] = 5'(base + i);
            dat[i] = 32'h1000_0000 + 32'(base * 16 + i);
            br[i]  = 1'(i & 1);
            ex[i]  = 1'((i >> 1) & 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rob[i] = 0; dat[i] = 0; br[i] = 0; ex[i] = 0;
        end
        v = '0;
        @(posedge clk);
        #1;

        phase = "reset";
        set_all(4'b1111, 1);
        step(1'b1, 1'b0);

        phase = "basic";
        set_all(4'b1111, 1);
        step(1'b0, 1'b0);
        check("ready_const", 32'(last_ready), 32'h3);
        check("l1_const", 32'(CDB_ROBEN1), 32'd1);
        check("l2_const", 32'(CDB_ROBEN2), 32'd2);
        check("rr_const", 32'(rr_ptr), 32'd2);

        phase = "rotate";
        set_all(4'b1111, 5);
        step(1'b0, 1'b0);
        check("rr_a", 32'(rr_ptr), 32'd0);
        check("l1_a", 32'(CDB_ROBEN1), 32'd7);
        set_all(4'b1111, 9);
        step(1'b0, 1'b0);
        check("rr_b", 32'(rr_ptr), 32'd2);
        check("l1_b", 32'(CDB_ROBEN1), 32'd9);

        phase = "single";
        v = 4'b0100;
        rob[2] = 5'd7; dat[2] = 32'hDEAD_BEEF; ex[2] = 1'b1; br[2] = 1'b0;
        step(1'b0, 1'b0);
        check("dat_const", CDB_ROBEN1_Write_Data, 32'hDEAD_BEEF);
        check("rr_const", 32'(rr_ptr), 32'd3);

        phase = "zero_roben";
        v = 4'b1000;
        rob[3] = 5'd0;
        step(1'b0, 1'b0);
        check("rr_hold", 32'(rr_ptr), 32'd3);

        phase = "flush";
        set_all(4'b1111, 20);
        step(1'b0, 1'b1);
        check("rr_hold", 32'(rr_ptr), 32'd3);
        step(1'b0, 1'b0);
        check("l1_resume", 32'(CDB_ROBEN1), 32'd23);
        check("l2_resume", 32'(CDB_ROBEN2), 32'd20);

        phase = "mid_reset";
        set_all(4'b1111, 3);
        step(1'b1, 1'b0);

        phase = "random";
        for (int i = 0; i < 4; i++) new_payload(i);
        for (int c = 0; c < 600; c++) begin
            bit r, f;
            r = ($urandom_range(0, 31) == 0);
            f = ($urandom_range(0, 9) == 0);
            step(r, f);
            for (int i = 0; i < 4; i++) begin
                if (last_ready[i] || (!(v[i] && rob[i] != 0) && $urandom_range(0, 3) == 0))
                    new_payload(i);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
